// File: rtl/io_port_pkg.sv
// Shared constants and helpers for the I/O port controller and its benches.
package io_port_pkg;

  localparam int NPORT_DEF = 4;
  localparam int DW_DEF    = 15;
  localparam int OW_DEF    = 23;
  localparam int DEPTH_DEF = 2;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-port synchronous FIFO holding upstream samples for one I/O port.
module io_fifo
  import io_port_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                din,
  output logic [DW-1:0]                head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; an empty level makes stale words unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// I/O port controller: per-port input FIFOs feeding the processor's io_in bus
// and registered per-port capture of io_out, with sticky error flags.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int DW    = DW_DEF,
  parameter int OW    = OW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NPORT*DW-1:0]                s_data,
  input  logic [NPORT-1:0]                   s_valid,
  output logic [NPORT-1:0]                   s_ready,
  input  logic [NPORT-1:0]                   req_in,
  output logic [DW-1:0]                      io_in,
  input  logic [OW-1:0]                      io_out,
  input  logic [NPORT-1:0]                   out_en,
  output logic [NPORT*OW-1:0]                m_data,
  output logic [NPORT-1:0]                   m_valid,
  output logic [NPORT*$clog2(DEPTH+1)-1:0]   in_level,
  output logic [NPORT-1:0]                   underrun,
  output logic                               multi_err,
  input  logic                               clr_flags
);

  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0]    head [NPORT];
  logic [NPORT-1:0] full, empty, push, pop, underrun_set;
  logic             req_one, out_one, multi_set;

  logic             ready_en_q, ready_en_d;
  logic [OW-1:0]    m_data_q [NPORT];
  logic [OW-1:0]    m_data_d [NPORT];
  logic [NPORT-1:0] m_valid_q, m_valid_d;
  logic [NPORT-1:0] underrun_q, underrun_d;
  logic             multi_err_q, multi_err_d;

  for (genvar k = 0; k < NPORT; k++) begin : g_port
    io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (s_data[k*DW +: DW]),
      .head  (head[k]),
      .level (in_level[k*LW +: LW]),
      .full  (full[k]),
      .empty (empty[k])
    );
    assign m_data[k*OW +: OW] = m_data_q[k];
  end

  // ready_en_q holds s_ready low through reset and for the release cycle.
  assign s_ready      = {NPORT{ready_en_q}} & ~full;
  assign push         = s_valid & s_ready;
  assign req_one      = is_onehot(32'(req_in));
  assign out_one      = is_onehot(32'(out_en));
  assign pop          = req_one ? (req_in & ~empty) : '0;
  assign underrun_set = req_one ? (req_in & empty) : '0;
  assign multi_set    = ((req_in != '0) && !req_one) || ((out_en != '0) && !out_one);

  assign m_valid   = m_valid_q;
  assign underrun  = underrun_q;
  assign multi_err = multi_err_q;

  always_comb begin
    io_in = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (pop[k]) io_in = head[k];
    end
  end

  // Errors raised in the same cycle as clr_flags still set the flag.
  always_comb begin
    ready_en_d  = 1'b1;
    underrun_d  = (clr_flags ? '0 : underrun_q) | underrun_set;
    multi_err_d = (clr_flags ? 1'b0 : multi_err_q) | multi_set;
    m_valid_d   = out_one ? out_en : '0;
    m_data_d    = m_data_q;
    for (int k = 0; k < NPORT; k++) begin
      if (out_one && out_en[k]) m_data_d[k] = io_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q  <= 1'b0;
      m_valid_q   <= '0;
      underrun_q  <= '0;
      multi_err_q <= 1'b0;
      for (int k = 0; k < NPORT; k++) m_data_q[k] <= '0;
    end else begin
      ready_en_q  <= ready_en_d;
      m_valid_q   <= m_valid_d;
      underrun_q  <= underrun_d;
      multi_err_q <= multi_err_d;
      m_data_q    <= m_data_d;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_io_port_ctrl;
  import io_port_pkg::*;

  localparam int NPORT = NPORT_DEF;
  localparam int DW    = DW_DEF;
  localparam int OW    = OW_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int LW    = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NPORT*DW-1:0]   s_data;
  logic [NPORT-1:0]      s_valid, s_ready, req_in, out_en, m_valid, underrun;
  logic [DW-1:0]         io_in;
  logic [OW-1:0]         io_out;
  logic [NPORT*OW-1:0]   m_data;
  logic [NPORT*LW-1:0]   in_level;
  logic                  multi_err, clr_flags;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [DW-1:0]    mq [NPORT][$];
  logic [NPORT-1:0] exp_under;
  logic             exp_multi;
  logic [OW-1:0]    exp_m [NPORT];
  logic [NPORT-1:0] exp_mv;
  logic             ready_en;

  io_port_ctrl #(.NPORT(NPORT), .DW(DW), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .req_in(req_in), .io_in(io_in), .io_out(io_out), .out_en(out_en),
    .m_data(m_data), .m_valid(m_valid), .in_level(in_level),
    .underrun(underrun), .multi_err(multi_err), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lvl(input int k);
    return in_level[k*LW +: LW];
  endfunction

  function automatic logic [OW-1:0] mdat(input int k);
    return m_data[k*OW +: OW];
  endfunction

  function automatic logic [DW-1:0] exp_io_in();
    if ($countones(req_in) == 1)
      for (int k = 0; k < NPORT; k++)
        if (req_in[k] && mq[k].size() > 0) return mq[k][0];
    return '0;
  endfunction

  function automatic logic [NPORT-1:0] exp_ready();
    logic [NPORT-1:0] r;
    for (int k = 0; k < NPORT; k++) r[k] = ready_en && (mq[k].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NPORT; k++) begin
      mq[k].delete();
      exp_m[k] = '0;
    end
    exp_under = '0;
    exp_multi = 1'b0;
    exp_mv    = '0;
    ready_en  = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_edge();
    bit req1, out1;
    logic [NPORT-1:0] rdy;
    req1 = ($countones(req_in) == 1);
    out1 = ($countones(out_en) == 1);
    rdy  = exp_ready();
    if (clr_flags) begin
      exp_under = '0;
      exp_multi = 1'b0;
    end
    for (int k = 0; k < NPORT; k++) begin
      if (req1 && req_in[k]) begin
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        else exp_under[k] = 1'b1;
      end
      if (s_valid[k] && rdy[k]) mq[k].push_back(s_data[k*DW +: DW]);
      if (out1 && out_en[k]) exp_m[k] = io_out;
    end
    if ((req_in != 0 && !req1) || (out_en != 0 && !out1)) exp_multi = 1'b1;
    exp_mv   = out1 ? out_en : '0;
    ready_en = 1'b1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_data = '0; s_valid = '0; req_in = '0; out_en = '0; io_out = '0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    n_total++; if (s_ready !== 4'b0000) $display("[TB] FAIL reset_s_ready got=%b exp=0000", s_ready); else n_pass++;
    n_total++; if (in_level !== '0) $display("[TB] FAIL reset_level got=%h exp=0", in_level); else n_pass++;
    n_total++; if (m_valid !== '0 || m_data !== '0) $display("[TB] FAIL reset_m got=%b/%h exp=0/0", m_valid, m_data); else n_pass++;
    n_total++; if (underrun !== '0 || multi_err !== 1'b0) $display("[TB] FAIL reset_flags got=%b/%b exp=0/0", underrun, multi_err); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (s_ready !== 4'b0000) $display("[TB] FAIL release_s_ready got=%b exp=0000", s_ready); else n_pass++;
    tick();
    n_total++; if (s_ready !== 4'b1111) $display("[TB] FAIL post_release_s_ready got=%b exp=1111", s_ready); else n_pass++;
  endtask

  task automatic test_fill_drain();
    s_valid = 4'b0100; s_data[2*DW +: DW] = DW'(100);
    tick();
    s_data[2*DW +: DW] = DW'(-5);
    tick();
    idle();
    #1;
    n_total++; if (lvl(2) !== LW'(2)) $display("[TB] FAIL fill_level got=%0d exp=2", lvl(2)); else n_pass++;
    n_total++; if (s_ready[2] !== 1'b0) $display("[TB] FAIL fill_ready got=%b exp=0", s_ready[2]); else n_pass++;
    req_in = 4'b0100;
    #1;
    n_total++; if (io_in !== DW'(100)) $display("[TB] FAIL pop1_io_in got=%0d exp=100", $signed(io_in)); else n_pass++;
    tick();
    n_total++; if (s_ready[2] !== 1'b1) $display("[TB] FAIL reopen_ready got=%b exp=1", s_ready[2]); else n_pass++;
    n_total++; if (io_in !== DW'(-5)) $display("[TB] FAIL pop2_io_in got=%0d exp=-5", $signed(io_in)); else n_pass++;
    tick();
    req_in = '0;
    #1;
    n_total++; if (lvl(2) !== '0) $display("[TB] FAIL drain_level got=%0d exp=0", lvl(2)); else n_pass++;
  endtask

  task automatic test_underrun();
    s_valid = 4'b0001; s_data[0 +: DW] = DW'(7); req_in = 4'b0001;
    #1;
    n_total++; if (io_in !== '0) $display("[TB] FAIL under_io_in got=%0d exp=0", $signed(io_in)); else n_pass++;
    tick();
    s_valid = '0;
    #1;
    n_total++; if (underrun[0] !== 1'b1) $display("[TB] FAIL under_flag got=%b exp=1", underrun[0]); else n_pass++;
    n_total++; if (lvl(0) !== LW'(1)) $display("[TB] FAIL under_level got=%0d exp=1", lvl(0)); else n_pass++;
    n_total++; if (io_in !== DW'(7)) $display("[TB] FAIL under_next got=%0d exp=7", $signed(io_in)); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_multi_err();
    s_valid = 4'b0011; s_data[0 +: DW] = DW'(11); s_data[DW +: DW] = DW'(22);
    tick();
    idle();
    req_in = 4'b0011;
    #1;
    n_total++; if (io_in !== '0) $display("[TB] FAIL multi_io_in got=%0d exp=0", $signed(io_in)); else n_pass++;
    tick();
    req_in = '0;
    n_total++; if (lvl(0) !== LW'(1) || lvl(1) !== LW'(1)) $display("[TB] FAIL multi_levels got=%0d,%0d exp=1,1", lvl(0), lvl(1)); else n_pass++;
    n_total++; if (multi_err !== 1'b1) $display("[TB] FAIL multi_flag got=%b exp=1", multi_err); else n_pass++;
    clr_flags = 1'b1; out_en = 4'b0110; io_out = OW'(99);
    tick();
    n_total++; if (multi_err !== 1'b1) $display("[TB] FAIL set_wins got=%b exp=1", multi_err); else n_pass++;
    n_total++; if (m_valid !== 4'b0000) $display("[TB] FAIL multi_no_capture got=%b exp=0000", m_valid); else n_pass++;
    out_en = '0;
    tick();
    n_total++; if (multi_err !== 1'b0 || underrun !== '0) $display("[TB] FAIL clr_flags got=%b/%b exp=0/0", multi_err, underrun); else n_pass++;
    idle();
    req_in = 4'b0001; tick();
    req_in = 4'b0010; tick();
    idle();
  endtask

  task automatic test_capture();
    out_en = 4'b0001; io_out = OW'(23'h12345);
    tick();
    out_en = 4'b1000; io_out = OW'(-1234);
    tick();
    out_en = '0; io_out = '0;
    n_total++; if (mdat(3) !== OW'(-1234)) $display("[TB] FAIL cap_data got=%0d exp=-1234", $signed(mdat(3))); else n_pass++;
    n_total++; if (m_valid !== 4'b1000) $display("[TB] FAIL cap_valid got=%b exp=1000", m_valid); else n_pass++;
    n_total++; if (mdat(0) !== OW'(23'h12345) || mdat(1) !== '0) $display("[TB] FAIL cap_hold got=%h,%h exp=12345,0", mdat(0), mdat(1)); else n_pass++;
    tick();
    n_total++; if (m_valid !== 4'b0000) $display("[TB] FAIL cap_pulse got=%b exp=0000", m_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    s_valid = 4'b0010; s_data[DW +: DW] = DW'(333);
    tick();
    idle();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_total++; if (lvl(1) !== '0) $display("[TB] FAIL midrst_level got=%0d exp=0", lvl(1)); else n_pass++;
    n_total++; if (m_data !== '0) $display("[TB] FAIL midrst_mdata got=%h exp=0", m_data); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    req_in = 4'b0010;
    #1;
    n_total++; if (io_in !== '0) $display("[TB] FAIL midrst_io_in got=%0d exp=0", $signed(io_in)); else n_pass++;
    tick();
    idle();
    n_total++; if (underrun[1] !== 1'b1) $display("[TB] FAIL midrst_under got=%b exp=1", underrun[1]); else n_pass++;
  endtask

  task automatic test_random();
    int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < NPORT; k++) s_data[k*DW +: DW] = DW'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3) req_in = '0;
      else if (r < 9) req_in = 4'(1 << $urandom_range(0, NPORT-1));
      else req_in = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r < 5) out_en = '0;
      else if (r < 9) out_en = 4'(1 << $urandom_range(0, NPORT-1));
      else out_en = 4'($urandom_range(0, 15));
      io_out    = OW'($urandom);
      clr_flags = ($urandom_range(0, 15) == 0);
      #1;
      n_total++; if (io_in !== exp_io_in()) $display("[TB] FAIL rnd_io_in cyc=%0d got=%h exp=%h", cyc, io_in, exp_io_in()); else n_pass++;
      n_total++; if (s_ready !== exp_ready()) $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready()); else n_pass++;
      tick();
      for (int k = 0; k < NPORT; k++) begin
        n_total++; if (lvl(k) !== LW'(mq[k].size())) $display("[TB] FAIL rnd_level cyc=%0d port=%0d got=%0d exp=%0d", cyc, k, lvl(k), mq[k].size()); else n_pass++;
        n_total++; if (mdat(k) !== exp_m[k]) $display("[TB] FAIL rnd_mdata cyc=%0d port=%0d got=%h exp=%h", cyc, k, mdat(k), exp_m[k]); else n_pass++;
      end
      n_total++; if (m_valid !== exp_mv) $display("[TB] FAIL rnd_mvalid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_mv); else n_pass++;
      n_total++; if (underrun !== exp_under || multi_err !== exp_multi) $display("[TB] FAIL rnd_flags cyc=%0d got=%b/%b exp=%b/%b", cyc, underrun, multi_err, exp_under, exp_multi); else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underrun();
    test_multi_err();
    test_capture();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
